cellnet_source: RTL and testbench

CELLNET_SOURCE -- requirements
Module: cellnet_source

---
 rtl/cellnet_source_pkg.sv | 44 ++++
 rtl/cellnet_src_timer.sv | 46 ++++
 rtl/cellnet_source.sv | 206 ++++++++++++++++++++
 tb/tb_cellnet_source.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cellnet_source_pkg.sv
// -----------------------------------------------------------------------------
// cellnet_source_pkg
// Shared constants and helpers for the cellnet four-phase message source.
//
// The shared width/level macros (`ADDRESS_SIZE, `DATA_SIZE, `ON, `OFF)
// normally come from the project-wide hglobal.v header. When that header has
// not been seen, the fallback definitions below apply.
//
// Contents:
//   CNT_W     width of the sent counter and of the GAP/timeout timer
//   CNT_MAX   saturation value of the sent counter
//   sat_inc   saturating increment of a CNT_W-bit value
//   preload   timer load value for a window of N cycles (N-1, 0 for N=0)
// -----------------------------------------------------------------------------
`ifndef ADDRESS_SIZE
  `define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
  `define DATA_SIZE 8
`endif
`ifndef ON
  `define ON 1'b1
`endif
`ifndef OFF
  `define OFF 1'b0
`endif

package cellnet_source_pkg;

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Sent counter sticks at all-ones in unbounded runs instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // The timer is loaded on the edge that enters a state and reaches zero
  // after N-1 further edges, so the state occupies exactly N cycles.
  function automatic logic [CNT_W-1:0] preload(input int unsigned cycles);
    return (cycles == 0) ? '0 : CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/cellnet_src_timer.sv
// -----------------------------------------------------------------------------
// cellnet_src_timer
// Loadable down-counter with zero flag. Shared between the inter-message gap
// count and the ack timeout count, which are never active at the same time.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset (count cleared to 0)
//   load_i      load load_val_i on the next edge (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one on the next edge, holding at zero
//   zero_o      count is zero
// -----------------------------------------------------------------------------
module cellnet_src_timer
  import cellnet_source_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cellnet_source.sv
// -----------------------------------------------------------------------------
// cellnet_source
// Four-phase request/acknowledge message source. On i_start it emits a run of
// MSG_COUNT messages (0 = unbounded) to DEST_ADDR, each carrying the next value
// of a free-running sequence that starts at 1 after reset and keeps counting
// across runs. GAP_CYCLES idle cycles separate one ack release from the next
// request.
//
// Optional feature: define CELLNET_SRC_TIMEOUT_EN to abort into a sticky ERR
// state when REQ or REL waits TIMEOUT_CYCLES cycles for the ack level. Without
// it the block waits indefinitely and o_err is tied off.
//
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset
//   i_start  level; starts a run when sampled high in IDLE with i_ack low
//   o_addr   destination address (constant DEST_ADDR)
//   o_dat    payload of the current message
//   o_req    four-phase request
//   i_ack    four-phase acknowledge from the sink
//   o_busy   high outside IDLE, DONE and ERR
//   o_done   high while in DONE
//   o_err    sticky ack-timeout flag
// -----------------------------------------------------------------------------
`ifndef ADDRESS_SIZE
  `define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
  `define DATA_SIZE 8
`endif
`ifndef ON
  `define ON 1'b1
`endif
`ifndef OFF
  `define OFF 1'b0
`endif

module cellnet_source
  import cellnet_source_pkg::*;
#(
  parameter int unsigned DEST_ADDR      = 1,
  parameter int unsigned ASZ            = `ADDRESS_SIZE,
  parameter int unsigned DSZ            = `DATA_SIZE,
  parameter int unsigned MSG_COUNT      = 8,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  output logic [ASZ-1:0] o_addr,
  output logic [DSZ-1:0] o_dat,
  output logic           o_req,
  input  logic           i_ack,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_REL,
    S_GAP,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [CNT_W-1:0] GAP_LOAD  = preload(GAP_CYCLES);
  localparam logic [CNT_W-1:0] TO_LOAD   = preload(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] MSG_LIMIT = CNT_W'(MSG_COUNT);

  state_e           state_q, state_d;
  logic [DSZ-1:0]   seq_q, seq_d;
  logic [DSZ-1:0]   dat_q, dat_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] sent_inc;
  logic             req_q, busy_q, done_q;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             to_expired;

  cellnet_src_timer u_timer (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign sent_inc = sat_inc(sent_q);

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    sent_d  = sent_q;
    dat_d   = dat_q;

    unique case (state_q)
      S_IDLE: begin
        // A sink still holding ack from a previous exchange blocks the start.
        if (i_start && !i_ack) begin
          state_d = S_REQ;
          sent_d  = '0;
        end
      end
      S_REQ: begin
        if (i_ack) begin
          state_d = S_REL;
        end else if (to_expired) begin
          state_d = S_ERR;
        end
      end
      S_REL: begin
        if (!i_ack) begin
          seq_d  = seq_q + 1'b1;
          sent_d = sent_inc;
          if ((MSG_COUNT != 0) && (sent_inc == MSG_LIMIT)) begin
            state_d = S_DONE;
          end else if (GAP_CYCLES == 0) begin
            state_d = S_REQ;
          end else begin
            state_d = S_GAP;
          end
        end else if (to_expired) begin
          state_d = S_ERR;
        end
      end
      S_GAP: begin
        if (tmr_zero) begin
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        if (!i_start) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Payload is latched only on REQ entry, which keeps it stable through the
    // whole handshake; seq_d already holds the incremented value on REL->REQ.
    if ((state_d == S_REQ) && (state_q != S_REQ)) begin
      dat_d = seq_d;
    end

    // Every state change reloads the timer for the state being entered.
    tmr_load = (state_d != state_q);
    tmr_dec  = !tmr_load;
    tmr_val  = (state_d == S_GAP) ? GAP_LOAD : TO_LOAD;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      seq_q   <= DSZ'(1);
      sent_q  <= '0;
      dat_q   <= '0;
      req_q   <= `OFF;
      busy_q  <= `OFF;
      done_q  <= `OFF;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      sent_q  <= sent_d;
      dat_q   <= dat_d;
      req_q   <= (state_d == S_REQ) ? `ON : `OFF;
      busy_q  <= (state_d inside {S_IDLE, S_DONE, S_ERR}) ? `OFF : `ON;
      done_q  <= (state_d == S_DONE) ? `ON : `OFF;
    end
  end

`ifdef CELLNET_SRC_TIMEOUT_EN
  logic err_q;

  assign to_expired = tmr_zero;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= `OFF;
    end else if (state_d == S_ERR) begin
      err_q <= `ON;
    end
  end

  assign o_err = err_q;
`else
  assign to_expired = 1'b0;
  assign o_err      = `OFF;
`endif

  assign o_addr = ASZ'(DEST_ADDR);
  assign o_dat  = dat_q;
  assign o_req  = req_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_cellnet_source.sv
// -----------------------------------------------------------------------------
// tb_cellnet_source
// Four source instances with different parameter sets share one clock:
//   0: MSG_COUNT=4, GAP_CYCLES=2, DEST_ADDR=5   (cycle table + scored run)
//   1: DSZ=4, MSG_COUNT=0, GAP_CYCLES=0         (unbounded, sequence wrap)
//   2: MSG_COUNT=3, GAP_CYCLES=1                (two consecutive runs)
//   3: MSG_COUNT=2, TIMEOUT_CYCLES=8            (ack never arrives)
// A behavioural sink acknowledges the selected instance one cycle after each
// request, pops the expected payload from the scoreboard queue and tracks
// payload stability through each handshake.
// -----------------------------------------------------------------------------
module tb_cellnet_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_v, start_v, man_ack, ack_v;
  logic [3:0] req_v, busy_v, done_v, err_v;
  logic [7:0] addr_a, addr_b, addr_c, addr_d;
  logic [7:0] dat_a, dat_c, dat_d;
  logic [3:0] dat_b;

  int         sel;
  logic       sink_en;
  logic       sink_ack;
  logic       sel_req;
  logic [7:0] sel_dat;
  logic [7:0] cap;
  logic [7:0] sb_exp;
  logic [7:0] sbq[$];
  int         rcv;
  int         sink_err;
  int         n_chk;
  int         n_fail;
  logic [7:0] model_seq[4];

  typedef struct packed {
    logic       rst;
    logic       start;
    logic       ack;
    logic       req;
    logic       busy;
    logic       done;
    logic [7:0] dat;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl[NV];

  cellnet_source #(.DEST_ADDR(5), .ASZ(8), .DSZ(8), .MSG_COUNT(4), .GAP_CYCLES(2))
  u_a (
    .i_clk(clk), .i_rst(rst_v[0]), .i_start(start_v[0]), .o_addr(addr_a),
    .o_dat(dat_a), .o_req(req_v[0]), .i_ack(ack_v[0]), .o_busy(busy_v[0]),
    .o_done(done_v[0]), .o_err(err_v[0])
  );

  cellnet_source #(.ASZ(8), .DSZ(4), .MSG_COUNT(0), .GAP_CYCLES(0))
  u_b (
    .i_clk(clk), .i_rst(rst_v[1]), .i_start(start_v[1]), .o_addr(addr_b),
    .o_dat(dat_b), .o_req(req_v[1]), .i_ack(ack_v[1]), .o_busy(busy_v[1]),
    .o_done(done_v[1]), .o_err(err_v[1])
  );

  cellnet_source #(.ASZ(8), .DSZ(8), .MSG_COUNT(3), .GAP_CYCLES(1))
  u_c (
    .i_clk(clk), .i_rst(rst_v[2]), .i_start(start_v[2]), .o_addr(addr_c),
    .o_dat(dat_c), .o_req(req_v[2]), .i_ack(ack_v[2]), .o_busy(busy_v[2]),
    .o_done(done_v[2]), .o_err(err_v[2])
  );

  cellnet_source #(.ASZ(8), .DSZ(8), .MSG_COUNT(2), .TIMEOUT_CYCLES(8))
  u_d (
    .i_clk(clk), .i_rst(rst_v[3]), .i_start(start_v[3]), .o_addr(addr_d),
    .o_dat(dat_d), .o_req(req_v[3]), .i_ack(ack_v[3]), .o_busy(busy_v[3]),
    .o_done(done_v[3]), .o_err(err_v[3])
  );

  for (genvar g = 0; g < 4; g++) begin : g_ack
    assign ack_v[g] = (sink_en && (sel == g)) ? sink_ack : man_ack[g];
  end

  always_comb begin
    sel_req = 1'b0;
    sel_dat = '0;
    case (sel)
      0: begin sel_req = req_v[0]; sel_dat = dat_a;          end
      1: begin sel_req = req_v[1]; sel_dat = {4'h0, dat_b};  end
      2: begin sel_req = req_v[2]; sel_dat = dat_c;          end
      3: begin sel_req = req_v[3]; sel_dat = dat_d;          end
      default: begin end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural sink: works on the negative edge so the source samples a
  // settled ack. It stalls (never acks) when no message is expected.
  always @(negedge clk) begin
    if (sink_en) begin
      if (sink_ack && (sel_dat != cap)) sink_err++;
      if (sel_req && !sink_ack && (sbq.size() > 0)) begin
        sb_exp = sbq.pop_front();
        check("sink payload", {24'h0, sel_dat}, {24'h0, sb_exp});
        cap      = sel_dat;
        sink_ack = 1'b1;
        rcv++;
      end else if (!sel_req && sink_ack) begin
        sink_ack = 1'b0;
      end
    end
  end

  function automatic vec_t mk(input logic [2:0] in_bits, input logic [2:0] out_bits,
                              input logic [7:0] d);
    return {in_bits, out_bits, d};
  endfunction

  task automatic push_run(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      sbq.push_back(model_seq[k]);
      model_seq[k] = (k == 1) ? ((model_seq[k] + 8'd1) & 8'h0F) : (model_seq[k] + 8'd1);
    end
  endtask

  task automatic pulse_start(input int k);
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_v[k]) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    int   cyc;

    n_chk = 0; n_fail = 0; rcv = 0; sink_err = 0;
    sel = -1; sink_en = 1'b0; sink_ack = 1'b0; cap = '0;
    rst_v = '1; start_v = '0; man_ack = '0;
    for (int i = 0; i < 4; i++) model_seq[i] = 8'd1;

    // {rst,start,ack}, {req,busy,done}, dat -- outputs after the edge
    tbl[0]  = mk(3'b011, 3'b000, 8'd0);  // ack held high: no request
    tbl[1]  = mk(3'b011, 3'b000, 8'd0);
    tbl[2]  = mk(3'b011, 3'b000, 8'd0);
    tbl[3]  = mk(3'b010, 3'b110, 8'd1);  // ack low: request with seq 1
    tbl[4]  = mk(3'b000, 3'b110, 8'd1);
    tbl[5]  = mk(3'b001, 3'b010, 8'd1);  // ack: req drops
    tbl[6]  = mk(3'b000, 3'b010, 8'd1);  // ack released -> gap
    tbl[7]  = mk(3'b000, 3'b010, 8'd1);
    tbl[8]  = mk(3'b000, 3'b110, 8'd2);  // two gap cycles then next request
    tbl[9]  = mk(3'b001, 3'b010, 8'd2);
    tbl[10] = mk(3'b001, 3'b010, 8'd2);  // ack held: payload stays
    tbl[11] = mk(3'b000, 3'b010, 8'd2);
    tbl[12] = mk(3'b000, 3'b010, 8'd2);
    tbl[13] = mk(3'b000, 3'b110, 8'd3);
    tbl[14] = mk(3'b101, 3'b000, 8'd0);  // reset with req=1, ack=1
    tbl[15] = mk(3'b011, 3'b000, 8'd0);
    tbl[16] = mk(3'b010, 3'b110, 8'd1);  // numbering restarts at 1
    tbl[17] = mk(3'b001, 3'b010, 8'd1);
    tbl[18] = mk(3'b000, 3'b010, 8'd1);
    tbl[19] = mk(3'b110, 3'b000, 8'd0);  // reset wins over start
    tbl[20] = mk(3'b000, 3'b000, 8'd0);

    tick();
    tick();
    rst_v = '0;

    check("reset req", {28'h0, req_v}, 32'h0);
    check("reset busy", {28'h0, busy_v}, 32'h0);
    check("reset done", {28'h0, done_v}, 32'h0);
    check("reset err", {28'h0, err_v}, 32'h0);
    check("reset dat a", {24'h0, dat_a}, 32'h0);
    check("reset dat b", {28'h0, dat_b}, 32'h0);
    check("addr a", {24'h0, addr_a}, 32'd5);
    check("addr b", {24'h0, addr_b}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      rst_v[0]   = tbl[i].rst;
      start_v[0] = tbl[i].start;
      man_ack[0] = tbl[i].ack;
      tick();
      check($sformatf("vec%0d req", i), {31'h0, req_v[0]}, {31'h0, tbl[i].req});
      check($sformatf("vec%0d busy", i), {31'h0, busy_v[0]}, {31'h0, tbl[i].busy});
      check($sformatf("vec%0d done", i), {31'h0, done_v[0]}, {31'h0, tbl[i].done});
      check($sformatf("vec%0d dat", i), {24'h0, dat_a}, {24'h0, tbl[i].dat});
    end
    model_seq[0] = 8'd1;

    // Bounded run of four messages with a one-cycle-ack sink.
    sel = 0; sink_en = 1'b1; rcv = 0; sink_err = 0;
    push_run(0, 4);
    pulse_start(0);
    wait_done(0, seen);
    check("A done seen", {31'h0, seen}, 32'd1);
    check("A msgs", rcv, 32'd4);
    check("A queue empty", sbq.size(), 32'd0);
    check("A sink err", sink_err, 32'd0);
    check("A last dat", {24'h0, dat_a}, 32'd4);
    check("A busy in done", {31'h0, busy_v[0]}, 32'd0);
    check("A err", {31'h0, err_v[0]}, 32'd0);
    tick();
    check("A done cleared", {31'h0, done_v[0]}, 32'd0);

    // Two runs of three: numbering continues into the second run.
    sel = 2; rcv = 0; sink_err = 0;
    push_run(2, 3);
    pulse_start(2);
    wait_done(2, seen);
    check("C run1 done", {31'h0, seen}, 32'd1);
    check("C run1 msgs", rcv, 32'd3);
    tick();
    push_run(2, 3);
    pulse_start(2);
    wait_done(2, seen);
    check("C run2 done", {31'h0, seen}, 32'd1);
    check("C total msgs", rcv, 32'd6);
    check("C last dat", {24'h0, dat_c}, 32'd6);
    check("C queue empty", sbq.size(), 32'd0);
    check("C sink err", sink_err, 32'd0);
    tick();

    // Unbounded 4-bit run: 1..15, 0, 1..4 then the sink stalls on 5.
    sel = 1; rcv = 0; sink_err = 0;
    push_run(1, 20);
    pulse_start(1);
    for (int i = 0; i < 400; i++) begin
      if (rcv >= 20) break;
      tick();
    end
    check("B msgs", rcv, 32'd20);
    tick(); tick(); tick();
    check("B stalled req", {31'h0, req_v[1]}, 32'd1);
    check("B next dat", {28'h0, dat_b}, 32'd5);
    check("B busy", {31'h0, busy_v[1]}, 32'd1);
    check("B no done", {31'h0, done_v[1]}, 32'd0);
    check("B sink err", sink_err, 32'd0);
    check("B queue empty", sbq.size(), 32'd0);
    rst_v[1] = 1'b1;
    tick();
    rst_v[1] = 1'b0;
    check("B req after reset", {31'h0, req_v[1]}, 32'd0);

    // Ack never rises on instance 3.
    sink_en = 1'b0; sel = -1; man_ack[3] = 1'b0;
    pulse_start(3);
    check("D req rise", {31'h0, req_v[3]}, 32'd1);
`ifdef CELLNET_SRC_TIMEOUT_EN
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (err_v[3]) begin
        cyc = k;
        break;
      end
    end
    check("D timeout cycles", cyc, 32'd8);
    check("D req after timeout", {31'h0, req_v[3]}, 32'd0);
    check("D busy in err", {31'h0, busy_v[3]}, 32'd0);
    pulse_start(3);
    for (int k = 0; k < 5; k++) tick();
    check("D err sticky", {31'h0, err_v[3]}, 32'd1);
    check("D no new req", {31'h0, req_v[3]}, 32'd0);
`else
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (err_v[3] || !req_v[3]) cyc++;
    end
    check("D waits forever", cyc, 32'd0);
    check("D still busy", {31'h0, busy_v[3]}, 32'd1);
`endif
    rst_v[3] = 1'b1;
    tick();
    rst_v[3] = 1'b0;
    check("D err after reset", {31'h0, err_v[3]}, 32'd0);
    check("D req after reset", {31'h0, req_v[3]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
